sec_bus_ctrl: RTL and testbench
===============================

# sec_bus_ctrl

Controller for the secondary bus that the primary cartridge-interface block exposes: `Addr`, `Rd`, `Wr`, write data, and the returned `SecDataRd`. It decodes the bus address into `NSLOTS` peripheral slots and turns level `Rd`/`Wr` into single-cycle per-slot strobes. It sequences read latency, registers the read data returned to the primary block, and counts protocol and decode errors. It sits between the primary block and all secondary logic (motor, servo and I/O peripherals) inside the top-level wrapper.

## Interface
- `NSLOTS`, 4: number of peripheral slots (1–8).
- `SLOT_LSB`, 16: lowest address bit of the slot field; the field is 3 bits wide (`SLOT_LSB+2:SLOT_LSB`).
- `BASE`, 5'h1F: required value of `Addr[23:19]` for any decoded access; `SLOT_LSB` must be 16 so that 5+3+16 = 24.
- `RD_LAT`, 2: cycles from slot read strobe to sampling `SlotDataRd` (1–7).
- `DEFAULT_RD`, 16'h0000: value returned for unmapped reads.

Ports:
- `Clk`  in  1  system clock; one clock domain.
- `Reset`  in  1  synchronous, active-high reset.
- `Addr`  in  24  bus address from the primary block, synchronous to `Clk`.
- `Rd`  in  1  read level, high for the whole access.
- `Wr`  in  1  write level, high for the whole access.
- `DataWr`  in  16  bus write data, valid while `Wr` is high.
- `SecDataRd`  out  16  registered read data to the primary block.
- `SlotSel`  out  NSLOTS  one-hot select of the slot being accessed, held for the access.
- `SlotRdStb`  out  NSLOTS  one-cycle read strobe.
- `SlotWrStb`  out  NSLOTS  one-cycle write strobe.
- `SlotAddr`  out  16  latched offset `Addr[15:0]`.
- `SlotDataWr`  out  16  latched write data.
- `SlotDataRd`  in  16*NSLOTS  flattened slot read data; slot k occupies bits `[16k+15:16k]`.
- `ErrCount`  out  8  saturating count of unmapped accesses and protocol errors.

## Operation
- Edge detection: `Rd_q` and `Wr_q` are one-cycle registered copies of `Rd`/`Wr`.
  - Rise = `X & ~X_q`.
  - Fall = `~X & X_q`.
- Decode: an access hits when `Addr[23:19]==BASE` and `Addr[18:16] < NSLOTS`; otherwise it is unmapped.
- The state machine has four states: IDLE, RD_WAIT, RD_HOLD, WR_HOLD.
  - IDLE, `Rd` rise, `Wr` low:
    - Latch `SlotAddr` and the decode.
    - On a hit: assert `SlotSel[k]` and pulse `SlotRdStb[k]` for exactly one cycle; load the latency counter with `RD_LAT-1`; go to RD_WAIT.
    - On a miss: load `SecDataRd=DEFAULT_RD`, increment `ErrCount`, go to RD_HOLD.
  - RD_WAIT: the counter decrements each cycle. At 0, load `SecDataRd` from slot k and go to RD_HOLD.
  - RD_HOLD: wait for `Rd` low, then drop `SlotSel` and return to IDLE.
  - IDLE, `Wr` rise, `Rd` low: latch `SlotAddr` and the decode, assert `SlotSel[k]`, go to WR_HOLD.
  - WR_HOLD: `SlotDataWr` tracks `DataWr` every cycle. On the `Wr` fall, pulse `SlotWrStb[k]` for one cycle, with `SlotDataWr` equal to the last data sampled while `Wr` was high, then return to IDLE.
  - A write miss produces no strobe and increments `ErrCount` once.
- Protocol errors:
  - `Rd` and `Wr` rising together: ignored, `ErrCount`+1, stay in IDLE until both are low.
  - `Rd` falls during RD_WAIT: abort to IDLE; `SecDataRd` is left unchanged; `ErrCount`+1.
  - `Wr` asserted during a read, or `Rd` during a write: `ErrCount`+1; the current access continues.
- `ErrCount` saturates at 8'hFF.
- `SecDataRd` holds its last value between reads.

## Timing
- Reset values: `SecDataRd`=0, `SlotSel`=0, strobes 0, `SlotAddr`=0, `SlotDataWr`=0, `ErrCount`=0, state IDLE.
- Reset while mid-access returns to IDLE immediately with no strobe emitted. The access still in progress after reset is ignored until its level drops.
- Read timing, taking the first cycle `Rd` is high as cycle 0:
  - `SlotRdStb` and `SlotSel` are high in cycle 1.
  - `SlotDataRd` is sampled at the end of cycle 1+`RD_LAT`.
  - `SecDataRd` is valid in cycle 2+`RD_LAT`.
- Write timing: `SlotWrStb` is high in the cycle after the first cycle `Wr` is low.
- Back-to-back accesses: a new rise is accepted in the cycle after the return to IDLE. The minimum gap is one low cycle.

## Structure
- Shared include `secbus_defs.v`: state encodings (IDLE=2'd0, RD_WAIT=2'd1, RD_HOLD=2'd2, WR_HOLD=2'd3), the slot-field width (3), and `ERR_MAX`=8'hFF.
- One natural sub-module: `strobe_edge` (registered level to rise/fall pulses), instantiated twice, once for `Rd` and once for `Wr`.

## Test plan
- Read from slot 2: `Addr`=24'hFA0010, `Rd` high 8 cycles, `SlotDataRd` slot2=16'h1234 -> one `SlotRdStb[2]` pulse in cycle 1, `SecDataRd`=16'h1234 in cycle 4 (`RD_LAT`=2), `SlotAddr`=16'h0010.
- Write to slot 0: `Addr`=24'hF80004, `DataWr` 16'hAAAA then 16'h5555 over 4 cycles -> a single `SlotWrStb[0]` pulse after `Wr` falls, with `SlotDataWr`=16'h5555.
- Unmapped read: `Addr`=24'h000000 -> `SecDataRd`=16'h0000, no strobes, `ErrCount`=1.
- Abort: `Rd` high for 2 cycles with `RD_LAT`=4 -> previous `SecDataRd` retained, `ErrCount`+1, IDLE on the next cycle.
- Simultaneous `Rd`/`Wr` rise, then 300 unmapped accesses -> no strobes, and `ErrCount` saturates at 8'hFF.
- `Reset` asserted during RD_WAIT -> all outputs 0 the next cycle, and no `SecDataRd` update even though `Rd` stays high.

Source files
------------

// File: rtl/sec_bus_ctrl_pkg.sv
// Shared definitions for the secondary bus controller.
//   state_e  : controller states (encodings match the bus documentation)
//   SLOT_W   : width of the slot field in the bus address
//   ERR_MAX  : saturation value of the error counter
package sec_bus_ctrl_pkg;

  localparam int unsigned SLOT_W = 3;
  localparam logic [7:0]  ERR_MAX = 8'hFF;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRdWait = 2'd1,
    StRdHold = 2'd2,
    StWrHold = 2'd3
  } state_e;

  // Saturating increment of the error counter.
  function automatic logic [7:0] err_inc(input logic [7:0] cnt);
    return (cnt == ERR_MAX) ? cnt : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/sec_bus_ctrl_strobe_edge.sv
// Level-to-edge converter for one bus control level.
//   i_clk  : system clock
//   i_lvl  : bus level (Rd or Wr)
//   o_rise : high in the first cycle the level is high
//   o_fall : high in the first cycle the level is low
module sec_bus_ctrl_strobe_edge (
  input  logic i_clk,
  input  logic i_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic r_lvl;

  // Deliberately not reset: during reset this copies the live level, so an
  // access already in progress when reset drops produces no rise and is
  // ignored until its level goes low.
  always_ff @(posedge i_clk) begin
    r_lvl <= i_lvl;
  end

  assign o_rise = i_lvl & ~r_lvl;
  assign o_fall = ~i_lvl & r_lvl;

endmodule

// File: rtl/sec_bus_ctrl.sv
// Secondary bus controller: decodes the primary block's bus into per-slot
// selects and one-cycle strobes, sequences read latency and counts errors.
//   Clk, Reset          : clock, synchronous active-high reset
//   Addr, Rd, Wr, DataWr: bus from the primary block
//   SecDataRd           : registered read data back to the primary block
//   SlotSel/RdStb/WrStb : one-hot slot select and strobes
//   SlotAddr/SlotDataWr : latched offset and write data
//   SlotDataRd          : flattened slot read data, slot k at [16k+15:16k]
//   ErrCount            : saturating unmapped/protocol error count
module sec_bus_ctrl
  import sec_bus_ctrl_pkg::*;
#(
  parameter int unsigned NSLOTS     = 4,
  parameter int unsigned SLOT_LSB   = 16,
  parameter logic [4:0]  BASE       = 5'h1F,
  parameter int unsigned RD_LAT     = 2,
  parameter logic [15:0] DEFAULT_RD = 16'h0000
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [23:0]          Addr,
  input  logic                 Rd,
  input  logic                 Wr,
  input  logic [15:0]          DataWr,
  output logic [15:0]          SecDataRd,
  output logic [NSLOTS-1:0]    SlotSel,
  output logic [NSLOTS-1:0]    SlotRdStb,
  output logic [NSLOTS-1:0]    SlotWrStb,
  output logic [15:0]          SlotAddr,
  output logic [15:0]          SlotDataWr,
  input  logic [16*NSLOTS-1:0] SlotDataRd,
  output logic [7:0]           ErrCount
);

  logic w_rd_rise, w_rd_fall, w_wr_rise, w_wr_fall;

  sec_bus_ctrl_strobe_edge u_rd_edge (
    .i_clk  (Clk),
    .i_lvl  (Rd),
    .o_rise (w_rd_rise),
    .o_fall (w_rd_fall)
  );

  sec_bus_ctrl_strobe_edge u_wr_edge (
    .i_clk  (Clk),
    .i_lvl  (Wr),
    .o_rise (w_wr_rise),
    .o_fall (w_wr_fall)
  );

  state_e            r_state, w_state_d;
  logic [2:0]        r_cnt, w_cnt_d;
  logic [SLOT_W-1:0] r_slot, w_slot_d;
  logic              r_block, w_block_d;
  logic [15:0]       r_sec_data_rd, w_sec_data_rd_d;
  logic [NSLOTS-1:0] r_slot_sel, w_slot_sel_d;
  logic [NSLOTS-1:0] r_slot_rd_stb, w_slot_rd_stb_d;
  logic [NSLOTS-1:0] r_slot_wr_stb, w_slot_wr_stb_d;
  logic [15:0]       r_slot_addr, w_slot_addr_d;
  logic [15:0]       r_slot_data_wr, w_slot_data_wr_d;
  logic [7:0]        r_err_cnt;
  logic              w_err;

  // Address decode of the live bus address.
  logic [SLOT_W-1:0] w_dec_slot;
  logic              w_hit;
  logic [NSLOTS-1:0] w_dec_sel;

  assign w_dec_slot = Addr[SLOT_LSB +: SLOT_W];
  assign w_hit      = (Addr[23:19] == BASE) && (32'(w_dec_slot) < NSLOTS);
  assign w_dec_sel  = w_hit ? (NSLOTS'(1) << w_dec_slot) : '0;

  // Read data of the latched slot.
  logic [15:0] w_slot_data;
  always_comb begin
    w_slot_data = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      if (r_slot == SLOT_W'(i)) w_slot_data = SlotDataRd[16*i +: 16];
    end
  end

  always_comb begin
    w_state_d        = r_state;
    w_cnt_d          = r_cnt;
    w_slot_d         = r_slot;
    w_block_d        = r_block;
    w_sec_data_rd_d  = r_sec_data_rd;
    w_slot_sel_d     = r_slot_sel;
    w_slot_rd_stb_d  = '0;
    w_slot_wr_stb_d  = '0;
    w_slot_addr_d    = r_slot_addr;
    w_slot_data_wr_d = r_slot_data_wr;
    w_err            = 1'b0;

    unique case (r_state)
      StIdle: begin
        // Select is kept through the write strobe cycle, released here.
        w_slot_sel_d = '0;
        if (r_block) begin
          if (!Rd && !Wr) w_block_d = 1'b0;
        end else if ((w_rd_rise || w_wr_rise) && Rd && Wr) begin
          w_err     = 1'b1;
          w_block_d = 1'b1;
        end else if (w_rd_rise) begin
          w_slot_addr_d = Addr[15:0];
          w_slot_d      = w_dec_slot;
          if (w_hit) begin
            w_slot_sel_d    = w_dec_sel;
            w_slot_rd_stb_d = w_dec_sel;
            w_cnt_d         = 3'(RD_LAT - 1);
            w_state_d       = StRdWait;
          end else begin
            w_sec_data_rd_d = DEFAULT_RD;
            w_err           = 1'b1;
            w_state_d       = StRdHold;
          end
        end else if (w_wr_rise) begin
          w_slot_addr_d    = Addr[15:0];
          w_slot_d         = w_dec_slot;
          w_slot_data_wr_d = DataWr;
          w_slot_sel_d     = w_dec_sel;
          w_err            = !w_hit;
          w_state_d        = StWrHold;
        end
      end
      StRdWait: begin
        if (w_wr_rise) w_err = 1'b1;
        if (w_rd_fall) begin
          w_err        = 1'b1;
          w_slot_sel_d = '0;
          w_state_d    = StIdle;
        end else if (r_slot_rd_stb != '0) begin
          // Counting starts after the strobe cycle.
          w_cnt_d = r_cnt;
        end else if (r_cnt == 3'd0) begin
          w_sec_data_rd_d = w_slot_data;
          w_state_d       = StRdHold;
        end else begin
          w_cnt_d = r_cnt - 3'd1;
        end
      end
      StRdHold: begin
        if (w_wr_rise) w_err = 1'b1;
        if (!Rd) begin
          w_slot_sel_d = '0;
          w_state_d    = StIdle;
        end
      end
      StWrHold: begin
        if (w_rd_rise) w_err = 1'b1;
        if (w_wr_fall) begin
          // Select is zero on a miss, so no strobe is produced.
          w_slot_wr_stb_d = r_slot_sel;
          w_state_d       = StIdle;
        end else begin
          w_slot_data_wr_d = DataWr;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state        <= StIdle;
      r_cnt          <= '0;
      r_slot         <= '0;
      r_block        <= 1'b0;
      r_sec_data_rd  <= '0;
      r_slot_sel     <= '0;
      r_slot_rd_stb  <= '0;
      r_slot_wr_stb  <= '0;
      r_slot_addr    <= '0;
      r_slot_data_wr <= '0;
      r_err_cnt      <= '0;
    end else begin
      r_state        <= w_state_d;
      r_cnt          <= w_cnt_d;
      r_slot         <= w_slot_d;
      r_block        <= w_block_d;
      r_sec_data_rd  <= w_sec_data_rd_d;
      r_slot_sel     <= w_slot_sel_d;
      r_slot_rd_stb  <= w_slot_rd_stb_d;
      r_slot_wr_stb  <= w_slot_wr_stb_d;
      r_slot_addr    <= w_slot_addr_d;
      r_slot_data_wr <= w_slot_data_wr_d;
      if (w_err) r_err_cnt <= err_inc(r_err_cnt);
    end
  end

  assign SecDataRd  = r_sec_data_rd;
  assign SlotSel    = r_slot_sel;
  assign SlotRdStb  = r_slot_rd_stb;
  assign SlotWrStb  = r_slot_wr_stb;
  assign SlotAddr   = r_slot_addr;
  assign SlotDataWr = r_slot_data_wr;
  assign ErrCount   = r_err_cnt;

endmodule

// File: tb/tb_sec_bus_ctrl.sv
module tb_sec_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] addr;
  logic        rd, wr;
  logic [15:0] data_wr;
  logic [63:0] slot_data_rd;

  logic [15:0] sec_data_rd, slot_addr, slot_data_wr;
  logic [3:0]  slot_sel, slot_rd_stb, slot_wr_stb;
  logic [7:0]  err_count;

  logic [15:0] sec_data_rd4, slot_addr4, slot_data_wr4;
  logic [3:0]  slot_sel4, slot_rd_stb4, slot_wr_stb4;
  logic [7:0]  err_count4;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_err;

  typedef struct {
    logic        is_wr;
    logic [3:0]  stb;
    logic [15:0] addr;
    logic [15:0] data;
  } sb_t;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  sec_bus_ctrl u_dut (
    .Clk(clk), .Reset(reset), .Addr(addr), .Rd(rd), .Wr(wr), .DataWr(data_wr),
    .SecDataRd(sec_data_rd), .SlotSel(slot_sel), .SlotRdStb(slot_rd_stb),
    .SlotWrStb(slot_wr_stb), .SlotAddr(slot_addr), .SlotDataWr(slot_data_wr),
    .SlotDataRd(slot_data_rd), .ErrCount(err_count)
  );

  sec_bus_ctrl #(.RD_LAT(4)) u_dut4 (
    .Clk(clk), .Reset(reset), .Addr(addr), .Rd(rd), .Wr(wr), .DataWr(data_wr),
    .SecDataRd(sec_data_rd4), .SlotSel(slot_sel4), .SlotRdStb(slot_rd_stb4),
    .SlotWrStb(slot_wr_stb4), .SlotAddr(slot_addr4), .SlotDataWr(slot_data_wr4),
    .SlotDataRd(slot_data_rd), .ErrCount(err_count4)
  );

  // Scoreboard: every strobe seen on the main DUT must match the oldest entry.
  always @(negedge clk) begin
    if (slot_rd_stb != 4'd0 || slot_wr_stb != 4'd0) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: rd_stb=%h wr_stb=%h with no strobe expected",
                 slot_rd_stb, slot_wr_stb);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        if (slot_rd_stb !== (e.is_wr ? 4'd0 : e.stb) || slot_wr_stb !== (e.is_wr ? e.stb : 4'd0)
            || slot_addr !== e.addr || (e.is_wr && slot_data_wr !== e.data)) begin
          bad++;
          $display("FAIL sb_strobe: got rd=%h wr=%h addr=%h data=%h want wr=%0b stb=%h addr=%h data=%h",
                   slot_rd_stb, slot_wr_stb, slot_addr, slot_data_wr,
                   e.is_wr, e.stb, e.addr, e.data);
        end
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic set_slot(input int k, input logic [15:0] v);
    slot_data_rd[16*k +: 16] = v;
  endtask

  task automatic push(input logic w, input logic [3:0] s, input logic [15:0] a,
                      input logic [15:0] d);
    sb_t e;
    e.is_wr = w; e.stb = s; e.addr = a; e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic check_err(input string name);
    total++;
    if (err_count !== exp_err) begin
      bad++;
      $display("FAIL %s: ErrCount=%h want %h", name, err_count, exp_err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; addr = '0; rd = 0; wr = 0; data_wr = '0; slot_data_rd = '0;
    step(3);
    reset = 1'b0;
    step(1);
    exp_err = 8'd0;
    total++;
    if ({sec_data_rd, slot_sel, slot_rd_stb, slot_wr_stb, slot_addr, slot_data_wr, err_count}
        !== '0) begin
      bad++;
      $display("FAIL reset_state: sec=%h sel=%h rd=%h wr=%h addr=%h dwr=%h err=%h",
               sec_data_rd, slot_sel, slot_rd_stb, slot_wr_stb, slot_addr, slot_data_wr,
               err_count);
    end
  endtask

  task automatic test_read_slot2();
    set_slot(0, 16'h1111); set_slot(1, 16'h2222); set_slot(2, 16'h1234); set_slot(3, 16'h4444);
    push(1'b0, 4'b0100, 16'h0010, 16'h0);
    addr = 24'hFA0010; rd = 1;
    for (int c = 1; c <= 8; c++) begin
      if (c == 8) rd = 0;
      step(1);
      if (c == 1) begin
        total++;
        if (slot_sel !== 4'b0100 || slot_rd_stb !== 4'b0100) begin
          bad++;
          $display("FAIL rd_cycle1: sel=%h stb=%h want 4 4", slot_sel, slot_rd_stb);
        end
      end
      if (c == 3) begin
        total++;
        if (sec_data_rd !== 16'h0000) begin
          bad++;
          $display("FAIL rd_early: SecDataRd=%h want 0000 in cycle 3", sec_data_rd);
        end
      end
      if (c == 4) begin
        total++;
        if (sec_data_rd !== 16'h1234 || slot_addr !== 16'h0010) begin
          bad++;
          $display("FAIL rd_data: sec=%h addr=%h want 1234 0010", sec_data_rd, slot_addr);
        end
      end
      if (c == 5) begin
        total++;
        if (sec_data_rd4 !== 16'h0000) begin
          bad++;
          $display("FAIL rd_lat4_early: sec4=%h want 0000", sec_data_rd4);
        end
      end
      if (c == 6) begin
        total++;
        if (sec_data_rd4 !== 16'h1234) begin
          bad++;
          $display("FAIL rd_lat4_data: sec4=%h want 1234", sec_data_rd4);
        end
      end
    end
    step(1);
    total++;
    if (slot_sel !== 4'd0) begin
      bad++;
      $display("FAIL rd_release: SlotSel=%h want 0", slot_sel);
    end
    step(1);
  endtask

  task automatic test_abort();
    set_slot(3, 16'hBEEF);
    push(1'b0, 4'b1000, 16'h0020, 16'h0);
    addr = 24'hFB0020; rd = 1;
    step(2);
    rd = 0;
    step(1);
    exp_err = exp_err + 8'd1;
    total++;
    if (slot_sel !== 4'd0 || sec_data_rd !== 16'h1234 || sec_data_rd4 !== 16'h1234
        || err_count4 !== exp_err) begin
      bad++;
      $display("FAIL abort: sel=%h sec=%h sec4=%h err4=%h want 0 1234 1234 %h",
               slot_sel, sec_data_rd, sec_data_rd4, err_count4, exp_err);
    end
    check_err("abort_err");
    step(3);
    total++;
    if (sec_data_rd !== 16'h1234) begin
      bad++;
      $display("FAIL abort_hold: SecDataRd=%h want 1234", sec_data_rd);
    end
  endtask

  task automatic test_unmapped_read();
    addr = 24'h000000; rd = 1;
    step(1);
    exp_err = exp_err + 8'd1;
    total++;
    if (sec_data_rd !== 16'h0000 || slot_sel !== 4'd0) begin
      bad++;
      $display("FAIL unmapped_rd: sec=%h sel=%h want 0000 0", sec_data_rd, slot_sel);
    end
    check_err("unmapped_err");
    step(2);
    rd = 0;
    step(2);
  endtask

  task automatic test_write_slot0();
    push(1'b1, 4'b0001, 16'h0004, 16'h5555);
    addr = 24'hF80004; wr = 1; data_wr = 16'hAAAA;
    step(1);
    total++;
    if (slot_sel !== 4'b0001 || slot_wr_stb !== 4'd0) begin
      bad++;
      $display("FAIL wr_sel: sel=%h wstb=%h want 1 0", slot_sel, slot_wr_stb);
    end
    step(1);
    data_wr = 16'h5555;
    step(2);
    wr = 0; data_wr = 16'hDEAD;
    step(1);
    total++;
    if (slot_wr_stb !== 4'b0001 || slot_data_wr !== 16'h5555) begin
      bad++;
      $display("FAIL wr_strobe: wstb=%h dwr=%h want 1 5555", slot_wr_stb, slot_data_wr);
    end
    step(1);
    total++;
    if (slot_wr_stb !== 4'd0 || slot_sel !== 4'd0) begin
      bad++;
      $display("FAIL wr_after: wstb=%h sel=%h want 0 0", slot_wr_stb, slot_sel);
    end
    check_err("wr_err");
  endtask

  task automatic test_back_to_back();
    set_slot(1, 16'h5A5A);
    push(1'b1, 4'b0010, 16'h0008, 16'h0F0F);
    push(1'b0, 4'b0010, 16'h000C, 16'h0);
    addr = 24'hF90008; wr = 1; data_wr = 16'h0F0F;
    step(2);
    wr = 0;
    step(1);
    addr = 24'hF9000C; rd = 1;
    step(4);
    total++;
    if (sec_data_rd !== 16'h5A5A || slot_addr !== 16'h000C) begin
      bad++;
      $display("FAIL b2b_read: sec=%h addr=%h want 5A5A 000C", sec_data_rd, slot_addr);
    end
    step(3);
    rd = 0;
    step(2);
    check_err("b2b_err");
  endtask

  task automatic test_simultaneous();
    addr = 24'hFA0000; rd = 1; wr = 1;
    step(1);
    exp_err = exp_err + 8'd1;
    check_err("simul_err");
    step(1);
    total++;
    if (slot_sel !== 4'd0) begin
      bad++;
      $display("FAIL simul_sel: SlotSel=%h want 0", slot_sel);
    end
    rd = 0;
    step(2);
    wr = 0;
    step(2);
    check_err("simul_err_once");
  endtask

  task automatic test_reset_mid_read();
    set_slot(2, 16'h7777);
    push(1'b0, 4'b0100, 16'h0010, 16'h0);
    addr = 24'hFA0010; rd = 1;
    step(1);
    reset = 1;
    step(1);
    reset = 0;
    exp_err = 8'd0;
    total++;
    if ({sec_data_rd, slot_sel, slot_rd_stb, slot_wr_stb, slot_addr, slot_data_wr, err_count}
        !== '0) begin
      bad++;
      $display("FAIL reset_mid: sec=%h sel=%h rstb=%h wstb=%h addr=%h dwr=%h err=%h",
               sec_data_rd, slot_sel, slot_rd_stb, slot_wr_stb, slot_addr, slot_data_wr,
               err_count);
    end
    step(5);
    total++;
    if (sec_data_rd !== 16'h0000 || sec_data_rd4 !== 16'h0000 || slot_sel !== 4'd0) begin
      bad++;
      $display("FAIL reset_ignored: sec=%h sec4=%h sel=%h want 0 0 0",
               sec_data_rd, sec_data_rd4, slot_sel);
    end
    rd = 0;
    step(2);
  endtask

  task automatic test_saturation();
    addr = 24'h000000;
    for (int i = 1; i <= 300; i++) begin
      rd = 1;
      step(1);
      rd = 0;
      step(1);
      if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
      if (i == 100) check_err("sat_mid");
    end
    check_err("sat_final");
  endtask

  initial begin
    test_reset();
    test_read_slot2();
    test_abort();
    test_unmapped_read();
    test_write_slot0();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid_read();
    test_saturation();
    step(2);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover: %0d expected strobes never seen, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
